// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller
// Reads the packed {hour, min, sec, msec} time word once per scan frame and
// multiplexes the selected field pair as four BCD digits onto a 4-digit
// common-anode 7-segment display. Anode and segment outputs are registered and active-low.
// Optional feature macro: FND_DP_BLINK_EN. When it is defined, the separator
// dp blinks at 1 Hz, driven by the snapshot msec field.
module fnd_scan_controller #(
    parameter int SCAN_DIV = 100_000,
    parameter int DP_DIGIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_time_data,
    input  logic        i_disp_sel,
    output logic [3:0]  o_fnd_com,
    output logic [7:0]  o_fnd_data,
    output logic        o_frame_tick
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [31:0]      snap_time;
    logic             snap_sel;

    logic             slot_tick;
    logic             frame_load;
    logic [1:0]       idx_nxt;
    logic [31:0]      time_nxt;
    logic             sel_nxt;
    logic [7:0]       low_f;
    logic [7:0]       high_f;
    logic [7:0]       field;
    logic [3:0]       bcd;
    logic [6:0]       seg;
    logic             dp_on;
    logic [7:0]       data_nxt;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one BCD digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // Slot/frame strobes and the digit pattern for the slot about to be shown.
    // NOTE: every always_comb output gets a default first, so no path can leave
    // a signal unassigned and infer a latch.
    always_comb begin
        slot_tick  = (cnt == CNT_W'(SCAN_DIV - 1));
        frame_load = slot_tick && (idx == 2'd3);
        idx_nxt    = idx + 2'd1;
        time_nxt   = frame_load ? i_time_data : snap_time;
        sel_nxt    = frame_load ? i_disp_sel  : snap_sel;
        bcd        = 4'd0;
        seg        = 7'h3F;

        // Decoding uses the incoming snapshot and index, so the new frame's
        // idx0 digit already reflects the freshly loaded word.
        low_f  = sel_nxt ? time_nxt[23:16] : time_nxt[7:0];
        high_f = sel_nxt ? time_nxt[31:24] : time_nxt[15:8];
        field  = idx_nxt[1] ? high_f : low_f;

        if (field < 8'd100) begin
            bcd = idx_nxt[0] ? 4'(field / 8'd10) : 4'(field % 8'd10);
            seg = seg7(bcd);
        end

        dp_on = (idx_nxt == 2'(DP_DIGIT));
`ifdef FND_DP_BLINK_EN
        dp_on = dp_on && (time_nxt[7:0] < 8'd50);
`else
        dp_on = dp_on;
`endif
        data_nxt = {~dp_on, seg};
    end

    // Prescaler, scan index and frame snapshot.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            idx       <= 2'd0;
            snap_time <= 32'd0;
            snap_sel  <= 1'b0;
        end else begin
            cnt <= slot_tick ? '0 : cnt + CNT_W'(1);
            if (slot_tick) begin
                idx <= idx_nxt;
            end
            if (frame_load) begin
                snap_time <= i_time_data;
                snap_sel  <= i_disp_sel;
            end
        end
    end

    // Registered display outputs. Anode and segments move on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_fnd_com    <= 4'b1111;
            o_fnd_data   <= 8'hFF;
            o_frame_tick <= 1'b0;
        end else begin
            o_frame_tick <= frame_load;
            if (slot_tick) begin
                o_fnd_com  <= ~(4'b0001 << idx_nxt);
                o_fnd_data <= data_nxt;
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench for fnd_scan_controller with SCAN_DIV = 4.
// The driver pushes the expected digit sequence when it applies a time word.
// A negedge monitor pops one entry each time the anode pattern changes.
module tb_fnd_scan_controller;

    localparam int SCAN_DIV = 4;

    typedef struct {
        logic [3:0] com;
        logic [7:0] data;
        logic       ft;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] i_time_data = 32'd0;
    logic        i_disp_sel = 1'b0;
    logic [3:0]  o_fnd_com;
    logic [7:0]  o_fnd_data;
    logic        o_frame_tick;

    exp_t        sb_q[$];
    logic [3:0]  prev_com = 4'b1111;
    int          n_checks = 0;
    int          n_fail = 0;

    fnd_scan_controller #(.SCAN_DIV(SCAN_DIV), .DP_DIGIT(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_time_data  (i_time_data),
        .i_disp_sel   (i_disp_sel),
        .o_fnd_com    (o_fnd_com),
        .o_fnd_data   (o_fnd_data),
        .o_frame_tick (o_frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] com, input logic [7:0] data, input logic ft);
        exp_t e;
        e.com  = com;
        e.data = data;
        e.ft   = ft;
        sb_q.push_back(e);
    endtask

    // Monitor: every anode change is one digit slot; compare it with the scoreboard.
    always @(negedge clk) begin
        if (rst && (o_fnd_com != prev_com) && (sb_q.size() > 0)) begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_com",  32'(o_fnd_com),    32'(e.com));
            check("sb_data", 32'(o_fnd_data),   32'(e.data));
            check("sb_ft",   32'(o_frame_tick), 32'(e.ft));
        end
        prev_com = o_fnd_com;
    end

    task automatic wait_com(input logic [3:0] target);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((o_fnd_com != target) && (n < 200));
        if (o_fnd_com != target) check("wait_com_timeout", 32'(o_fnd_com), 32'(target));
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb_q.size() != 0) && (n < 200)) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb_q.size() != 0) check("drain_timeout", sb_q.size(), 0);
    endtask

    initial begin
        // Held in reset: all digits blank.
        repeat (3) @(negedge clk);
        check("rst_com",  32'(o_fnd_com),    32'hF);
        check("rst_data", 32'(o_fnd_data),   32'hFF);
        check("rst_ft",   32'(o_frame_tick), 32'h0);

        // Release: outputs stay in reset state for SCAN_DIV-1 edges.
        rst = 1'b1;
        for (int i = 0; i < SCAN_DIV - 1; i++) begin
            @(negedge clk);
            check("post_rst_com",  32'(o_fnd_com),  32'hF);
            check("post_rst_data", 32'(o_fnd_data), 32'hFF);
        end
        @(negedge clk);
        #1;
        check("first_com",  32'(o_fnd_com),  32'hD);
        check("first_data", 32'(o_fnd_data), 32'hC0);

        // idx1 of the zero frame: load 0x0C1E2D07, sel=0, for the next frame.
        i_time_data = 32'h0C1E_2D07;
        i_disp_sel  = 1'b0;
        push(4'b1011, 8'h40, 1'b0);   // zero snapshot, digit 2 with dp
        push(4'b0111, 8'hC0, 1'b0);
        push(4'b1110, 8'hF8, 1'b1);   // 7
        push(4'b1101, 8'hC0, 1'b0);   // 0
        push(4'b1011, 8'h12, 1'b0);   // 5 with dp
        push(4'b0111, 8'h99, 1'b0);   // 4
        wait_drain();

        // Same word, hour.min.
        i_disp_sel = 1'b1;
        push(4'b1110, 8'hC0, 1'b1);   // 0
        push(4'b1101, 8'hB0, 1'b0);   // 3
        push(4'b1011, 8'h24, 1'b0);   // 2 with dp
        push(4'b0111, 8'hF9, 1'b0);   // 1
        wait_drain();

        // Change the inputs mid-frame at idx1: the rest of the frame keeps the old snapshot.
        wait_com(4'b1101);
        i_time_data = 32'h173B_3B7F;   // sec 59, msec 127
        i_disp_sel  = 1'b0;
        push(4'b1011, 8'h24, 1'b0);
        push(4'b0111, 8'hF9, 1'b0);
        push(4'b1110, 8'hBF, 1'b1);   // msec >= 100 -> dash
        push(4'b1101, 8'hBF, 1'b0);
`ifdef FND_DP_BLINK_EN
        push(4'b1011, 8'h90, 1'b0);   // 9, dp off (msec 127)
`else
        push(4'b1011, 8'h10, 1'b0);   // 9 with dp
`endif
        push(4'b0111, 8'h92, 1'b0);   // 5
        wait_drain();

        // msec = 49: separator lit in both builds.
        i_time_data = 32'h0000_0C31;
        push(4'b1110, 8'h90, 1'b1);   // 9
        push(4'b1101, 8'h99, 1'b0);   // 4
        push(4'b1011, 8'h24, 1'b0);   // 2 with dp
        push(4'b0111, 8'hF9, 1'b0);   // 1
        wait_drain();

        // msec = 50: separator off only with blink enabled.
        i_time_data = 32'h0000_0C32;
        push(4'b1110, 8'hC0, 1'b1);   // 0
        push(4'b1101, 8'h92, 1'b0);   // 5
`ifdef FND_DP_BLINK_EN
        push(4'b1011, 8'hA4, 1'b0);
`else
        push(4'b1011, 8'h24, 1'b0);
`endif
        push(4'b0111, 8'hF9, 1'b0);
        wait_drain();

        // Boundary: hour 100 dashes, min 99 stays numeric.
        i_time_data = 32'h6463_000A;
        i_disp_sel  = 1'b1;
        push(4'b1110, 8'h90, 1'b1);   // 9
        push(4'b1101, 8'h90, 1'b0);   // 9
        push(4'b1011, 8'h3F, 1'b0);   // dash with dp (msec 10)
        push(4'b0111, 8'hBF, 1'b0);   // dash
        wait_drain();

        // Asynchronous reset in the middle of a slot blanks the display at once.
        wait_com(4'b1011);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_com",  32'(o_fnd_com),    32'hF);
        check("midrst_data", 32'(o_fnd_data),   32'hFF);
        check("midrst_ft",   32'(o_frame_tick), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rerelease_com", 32'(o_fnd_com), 32'hF);

        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
